// File: rtl/oam_dma_pkg.sv
// ----------------------------------------------------------------------------
// oam_dma_pkg
//   Shared constants for the NES sprite DMA engine.
//   - DMA_S_* : FSM state encodings (DMA_S_BITS wide)
//   - DMA_TRIG_ADDR / DMA_DST_ADDR / DMA_XFER_LEN : default engine parameters
//   - is_dummy_state() : true for the halt cycles that do not touch memory
//   Build option: OAM_DMA_ALIGN_EN (see oam_dma.sv).
// ----------------------------------------------------------------------------
package oam_dma_pkg;

    localparam int DMA_S_BITS = 3;

    typedef logic [DMA_S_BITS-1:0] dma_state_t;

    localparam logic [2:0] DMA_S_IDLE  = 3'd0;
    localparam logic [2:0] DMA_S_HALT  = 3'd1;
    localparam logic [2:0] DMA_S_ALIGN = 3'd2;
    localparam logic [2:0] DMA_S_READ  = 3'd3;
    localparam logic [2:0] DMA_S_WRITE = 3'd4;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DMA_DST_ADDR  = 16'h2004;
    localparam int          DMA_XFER_LEN  = 256;

    // HALT and ALIGN are dummy cycles: the CPU is stalled but the DMA
    // has not yet started moving data.
    function automatic logic is_dummy_state(input dma_state_t s);
        return (s == DMA_S_HALT) || (s == DMA_S_ALIGN);
    endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// ----------------------------------------------------------------------------
// dma_bus_mux
//   Combinational selector that decides who owns the system bus.
//   Ports:
//     state              in  current DMA FSM state
//     cpu_a/cpu_dout/cpu_we  in  CPU bus request
//     dma_a/dma_dout/dma_we  in  DMA bus request (used in READ/WRITE)
//     bus_a/bus_dout/bus_we  out system bus
//   IDLE: CPU passes straight through.
//   HALT/ALIGN: CPU address/data shown, but writes are suppressed.
//   READ/WRITE: DMA drives the bus.
// ----------------------------------------------------------------------------
module dma_bus_mux
    import oam_dma_pkg::*;
(
    input  logic [2:0]  state,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_dout,
    input  logic        dma_we,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_we
);

    always_comb begin
        bus_a    = cpu_a;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        if (is_dummy_state(state)) begin
            bus_we = 1'b0;
        end else if ((state == DMA_S_READ) || (state == DMA_S_WRITE)) begin
            bus_a    = dma_a;
            bus_dout = dma_dout;
            bus_we   = dma_we;
        end
    end

endmodule

// File: rtl/oam_dma.sv
// ----------------------------------------------------------------------------
// oam_dma
//   NES sprite DMA engine sitting between the k6502 core and the system bus.
//   A CPU write to TRIG_ADDR halts the CPU (cpu_rdy=0) and copies XFER_LEN
//   bytes from page {written byte, 8'h00} to DST_ADDR using alternating
//   read/write bus cycles.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     cpu_a, cpu_dout, cpu_we  CPU bus request
//     cpu_rdy                  1 = CPU may advance
//     bus_a, bus_dout, bus_we  system bus outputs
//     bus_din                  system bus read data
//     dma_busy                 transfer in progress
//   Build option: define OAM_DMA_ALIGN_EN to insert one ALIGN dummy cycle
//   when the free-running parity flop is 1 in HALT (2A03 odd-cycle halt).
// ----------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = DMA_TRIG_ADDR,
    parameter logic [15:0] DST_ADDR  = DMA_DST_ADDR,
    parameter int          XFER_LEN  = DMA_XFER_LEN
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    input  logic [7:0]  bus_din,
    output logic        dma_busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [7:0]  idx_reg;
    logic [7:0]  page_reg;
    logic [7:0]  data_reg;
    logic        trig_hit;
    logic [15:0] dma_a;
    logic        dma_we;

    assign trig_hit = cpu_we && (cpu_a == TRIG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    // Free-running parity: tells HALT whether the transfer would start
    // on an odd cycle and needs one extra alignment cycle.
    logic par_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_reg <= 1'b0;
        end else begin
            par_reg <= ~par_reg;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DMA_S_IDLE:  if (trig_hit) state_next = DMA_S_HALT;
`ifdef OAM_DMA_ALIGN_EN
            DMA_S_HALT:  state_next = par_reg ? DMA_S_ALIGN : DMA_S_READ;
`else
            DMA_S_HALT:  state_next = DMA_S_READ;
`endif
            DMA_S_ALIGN: state_next = DMA_S_READ;
            DMA_S_READ:  state_next = DMA_S_WRITE;
            DMA_S_WRITE: state_next = (idx_reg == LAST_IDX) ? DMA_S_IDLE : DMA_S_READ;
            default:     state_next = DMA_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= DMA_S_IDLE;
            idx_reg   <= 8'h00;
            page_reg  <= 8'h00;
            data_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            // Triggers outside IDLE are ignored: page/idx only latch here.
            if ((state_reg == DMA_S_IDLE) && trig_hit) begin
                page_reg <= cpu_dout;
                idx_reg  <= 8'h00;
            end
            if (state_reg == DMA_S_READ) begin
                data_reg <= bus_din;
            end
            // Wraps 255->0 on the last write, leaving idx ready for next time.
            if (state_reg == DMA_S_WRITE) begin
                idx_reg <= idx_reg + 8'h01;
            end
        end
    end

    // Source address stays inside the latched page; idx never carries into it.
    assign dma_a    = (state_reg == DMA_S_WRITE) ? DST_ADDR : {page_reg, idx_reg};
    assign dma_we   = (state_reg == DMA_S_WRITE);
    assign cpu_rdy  = (state_reg == DMA_S_IDLE);
    assign dma_busy = (state_reg != DMA_S_IDLE);

    dma_bus_mux u_bus_mux (
        .state    (state_reg),
        .cpu_a    (cpu_a),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .dma_a    (dma_a),
        .dma_dout (data_reg),
        .dma_we   (dma_we),
        .bus_a    (bus_a),
        .bus_dout (bus_dout),
        .bus_we   (bus_we)
    );

endmodule
